// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//  Shared definitions for the MIPS program-counter datapath:
//   - default address / jump-index / branch-offset widths
//   - default reset PC and return-address-stack depth
//   - pc_sel_e: encoding of the next-PC source
//   - pc_select(): fixed-priority next-PC source selection
// ----------------------------------------------------------------------------
package mips_pkg;

  localparam int          ADDR_W_DEF    = 32;
  localparam int          IDX_W_DEF     = 26;
  localparam int          OFF_W_DEF     = 16;
  localparam int          RAS_DEPTH_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2,
    PC_JR  = 2'd3
  } pc_sel_e;

  // Register jumps beat J-type jumps, which beat taken branches. Anything
  // that loses in a cycle is dropped.
  function automatic pc_sel_e pc_select(input logic jump_reg,
                                        input logic jump,
                                        input logic branch_taken);
    pc_sel_e sel;
    if (jump_reg)          sel = PC_JR;
    else if (jump)         sel = PC_JMP;
    else if (branch_taken) sel = PC_BR;
    else                   sel = PC_SEQ;
    return sel;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// ----------------------------------------------------------------------------
// ras_stack
//  Circular return-address stack. r_ptr points at the next free slot, the
//  top of stack lives at r_ptr-1. When the stack is full a push simply keeps
//  writing around the ring, which overwrites the oldest entry while the count
//  saturates at DEPTH. A pop on an empty stack is ignored. A simultaneous
//  pop and push replaces the top entry in place.
//
// Ports
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous active-high reset (pointer/count)
//  i_push      in   1       push i_push_data
//  i_pop       in   1       pop the top entry (no-op when empty)
//  i_push_data in   W       return address to push
//  o_top       out  W       current top-of-stack entry
//  o_empty     out  1       no valid entries
// ----------------------------------------------------------------------------
module ras_stack
  import mips_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEF,
  parameter int W     = ADDR_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_push_data,
  output logic [W-1:0] o_top,
  output logic         o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic [PTR_W-1:0] w_top_idx;
  logic             w_do_pop;
  logic             w_full;

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign o_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign o_top     = r_mem[w_top_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_do_pop && i_push) begin
      // Pop then push: depth and pointer unchanged, top gets replaced below.
      r_ptr <= r_ptr;
      r_cnt <= r_cnt;
    end else if (w_do_pop) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (i_push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      r_cnt <= w_full ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  // Entry storage is pure data and carries no reset; validity is tracked by r_cnt.
  always_ff @(posedge clk) begin
    if (i_push) begin
      if (w_do_pop) r_mem[w_top_idx] <= i_push_data;
      else          r_mem[r_ptr]     <= i_push_data;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// ----------------------------------------------------------------------------
// next_pc_unit
//  Registered program-counter generator. Each unstalled cycle it picks the
//  next PC from sequential, branch, J/JAL or JR/JALR sources and keeps a
//  return-address stack that predicts JR $ra targets.
//
// Ports
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous active-high reset
//  stall        in   1       hold PC, RAS and flags; ignore requests
//  branch_taken in   1       conditional branch resolved taken
//  jump         in   1       J-type jump (J/JAL)
//  jump_link    in   1       request links (JAL/JALR)
//  jump_reg     in   1       register jump (JR/JALR)
//  is_return    in   1       register jump is JR $ra (RAS pop)
//  instr_idx    in   IDX_W   jump index field
//  branch_off   in   OFF_W   branch offset field (sign-extended)
//  reg_target   in   ADDR_W  rs value for JR/JALR
//  pc           out  ADDR_W  current PC (registered)
//  pc_plus4     out  ADDR_W  pc + 4
//  link_addr    out  ADDR_W  link value (= pc_plus4)
//  ras_empty    out  1       RAS holds no valid entry
//  ras_mispred  out  1       registered pulse: RAS top != reg_target on pop
//  misalign     out  1       registered pulse: selected target[1:0] != 0
// ----------------------------------------------------------------------------
module next_pc_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                IDX_W     = IDX_W_DEF,
  parameter int                OFF_W     = OFF_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
  parameter int                RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              jump_link,
  input  logic              jump_reg,
  input  logic              is_return,
  input  logic [IDX_W-1:0]  instr_idx,
  input  logic [OFF_W-1:0]  branch_off,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] link_addr,
  output logic              ras_empty,
  output logic              ras_mispred,
  output logic              misalign
);

  logic [ADDR_W-1:0]        r_pc;
  logic                     r_mispred;
  logic                     r_misalign;

  logic [ADDR_W-1:0]        w_pc_plus4;
  logic signed [ADDR_W-1:0] w_off_sext;
  logic [ADDR_W-1:0]        w_br_tgt;
  logic [ADDR_W-1:0]        w_jmp_tgt;
  logic [ADDR_W-1:0]        w_jr_tgt;
  logic [ADDR_W-1:0]        w_target;
  pc_sel_e                  w_sel;

  logic                     w_ras_push;
  logic                     w_ras_pop;
  logic [ADDR_W-1:0]        w_ras_top;
  logic                     w_ras_empty;
  logic                     w_use_ras;

  // Target arithmetic (all wraps modulo 2^ADDR_W)
  assign w_pc_plus4 = r_pc + ADDR_W'(4);
  assign w_off_sext = ADDR_W'($signed(branch_off));
  assign w_br_tgt   = w_pc_plus4 + $unsigned(w_off_sext <<< 2);
  assign w_jmp_tgt  = {w_pc_plus4[ADDR_W-1:IDX_W+2], instr_idx, 2'b00};

  // A return only trusts the RAS when it actually holds something.
  assign w_use_ras  = is_return && !w_ras_empty;
  assign w_jr_tgt   = w_use_ras ? w_ras_top : reg_target;

  assign w_sel = pc_select(jump_reg, jump, branch_taken);

  always_comb begin
    w_target = w_pc_plus4;
    case (w_sel)
      PC_JR:   w_target = w_jr_tgt;
      PC_JMP:  w_target = w_jmp_tgt;
      PC_BR:   w_target = w_br_tgt;
      default: w_target = w_pc_plus4;
    endcase
  end

  // Only a winning, unstalled request touches the stack.
  assign w_ras_push = !stall && jump_link && ((w_sel == PC_JMP) || (w_sel == PC_JR));
  assign w_ras_pop  = !stall && is_return && (w_sel == PC_JR);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_ras_push),
    .i_pop       (w_ras_pop),
    .i_push_data (w_pc_plus4),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty)
  );

  // PC and flag registers: flags hold through a stall like the PC does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_mispred  <= 1'b0;
      r_misalign <= 1'b0;
    end else if (!stall) begin
      r_pc       <= {w_target[ADDR_W-1:2], 2'b00};
      r_misalign <= (w_target[1:0] != 2'b00);
      r_mispred  <= w_ras_pop && !w_ras_empty && (w_ras_top != reg_target);
    end
  end

  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign link_addr   = w_pc_plus4;
  assign ras_empty   = w_ras_empty;
  assign ras_mispred = r_mispred;
  assign misalign    = r_misalign;

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic        jump_link;
  logic        jump_reg;
  logic        is_return;
  logic [25:0] instr_idx;
  logic [15:0] branch_off;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] link_addr;
  logic        ras_empty;
  logic        ras_mispred;
  logic        misalign;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        mis;
    logic        misp;
    logic        empty;
  } exp_t;

  exp_t exp_q[$];

  next_pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jump_link    (jump_link),
    .jump_reg     (jump_reg),
    .is_return    (is_return),
    .instr_idx    (instr_idx),
    .branch_off   (branch_off),
    .reg_target   (reg_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .link_addr    (link_addr),
    .ras_empty    (ras_empty),
    .ras_mispred  (ras_mispred),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; jump_link = 0;
    jump_reg = 0; is_return = 0; instr_idx = '0; branch_off = '0; reg_target = '0;
  endtask

  task automatic expect_next(input string tag, input logic [31:0] epc,
                             input logic emis, input logic emisp, input logic eempty);
    exp_t e;
    e.tag = tag; e.pc = epc; e.mis = emis; e.misp = emisp; e.empty = eempty;
    exp_q.push_back(e);
  endtask

  // Clock the request in, then check the DUT output against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    n_vec++;
    assert (exp_q.size() != 0) else begin
      n_miss++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp({e.tag, ".pc"},       pc,          e.pc);
      cmp({e.tag, ".pc4"},      pc_plus4,    e.pc + 32'd4);
      cmp({e.tag, ".link"},     link_addr,   e.pc + 32'd4);
      cmp({e.tag, ".misalign"}, 32'(misalign),    32'(e.mis));
      cmp({e.tag, ".mispred"},  32'(ras_mispred), 32'(e.misp));
      cmp({e.tag, ".empty"},    32'(ras_empty),   32'(e.empty));
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    cmp("rst.pc",      pc,                 32'h0);
    cmp("rst.empty",   32'(ras_empty),     32'd1);
    cmp("rst.mispred", 32'(ras_mispred),   32'd0);
    cmp("rst.misalign",32'(misalign),      32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Sequential advance
    expect_next("seq", 32'h4, 0, 0, 1); step();

    // J-type jump keeps the upper PC bits
    jump_reg = 1; reg_target = 32'h1000_0000;
    expect_next("jr_hi", 32'h1000_0000, 0, 0, 1); step();
    jump = 1; instr_idx = 26'h100;
    expect_next("jump", 32'h1000_0400, 0, 0, 1); step();

    // Branches with negative and positive offsets
    jump_reg = 1; reg_target = 32'h10;
    expect_next("jr_10a", 32'h10, 0, 0, 1); step();
    branch_taken = 1; branch_off = 16'hFFFC;
    expect_next("br_neg", 32'h4, 0, 0, 1); step();
    jump_reg = 1; reg_target = 32'h10;
    expect_next("jr_10b", 32'h10, 0, 0, 1); step();
    branch_taken = 1; branch_off = 16'h0001;
    expect_next("br_pos", 32'h18, 0, 0, 1); step();

    // JAL at 0x20 then JR $ra
    jump = 1; instr_idx = 26'h8;
    expect_next("j_20", 32'h20, 0, 0, 1); step();
    jump = 1; jump_link = 1; instr_idx = 26'h40;
    expect_next("jal", 32'h100, 0, 0, 0); step();
    jump_reg = 1; is_return = 1; reg_target = 32'h24;
    expect_next("ret", 32'h24, 0, 0, 1); step();

    // Five pushes onto a four-deep stack: 0x28 is overwritten
    jump = 1; jump_link = 1; instr_idx = 26'h10;
    expect_next("push1", 32'h40, 0, 0, 0); step();
    jump = 1; jump_link = 1; instr_idx = 26'h20;
    expect_next("push2", 32'h80, 0, 0, 0); step();
    jump = 1; jump_link = 1; instr_idx = 26'h30;
    expect_next("push3", 32'hC0, 0, 0, 0); step();
    jump = 1; jump_link = 1; instr_idx = 26'h40;
    expect_next("push4", 32'h100, 0, 0, 0); step();
    jump = 1; jump_link = 1; instr_idx = 26'h50;
    expect_next("push5", 32'h140, 0, 0, 0); step();

    // LIFO pops; the second one disagrees with reg_target
    jump_reg = 1; is_return = 1; reg_target = 32'h104;
    expect_next("pop1", 32'h104, 0, 0, 0); step();
    jump_reg = 1; is_return = 1; reg_target = 32'h0;
    expect_next("pop2", 32'hC4, 0, 1, 0); step();
    jump_reg = 1; is_return = 1; reg_target = 32'h84;
    expect_next("pop3", 32'h84, 0, 0, 0); step();
    jump_reg = 1; is_return = 1; reg_target = 32'h44;
    expect_next("pop4", 32'h44, 0, 0, 1); step();
    jump_reg = 1; is_return = 1; reg_target = 32'h300;
    expect_next("pop5_empty", 32'h300, 0, 0, 1); step();

    // Stall holds the PC; combined requests take the register target
    stall = 1; jump = 1; instr_idx = 26'h10;
    expect_next("stall", 32'h300, 0, 0, 1); step();
    jump_reg = 1; jump = 1; branch_taken = 1; reg_target = 32'h500;
    instr_idx = 26'h10; branch_off = 16'h0010;
    expect_next("prio", 32'h500, 0, 0, 1); step();

    // Misaligned register target; the pulse holds through a stall
    jump_reg = 1; reg_target = 32'h102;
    expect_next("misal", 32'h100, 1, 0, 1); step();
    stall = 1; jump = 1; instr_idx = 26'h3;
    expect_next("misal_hold", 32'h100, 1, 0, 1); step();
    expect_next("misal_clr", 32'h104, 0, 0, 1); step();

    // JALR with is_return replaces the top of stack
    jump = 1; jump_link = 1; instr_idx = 26'h80;
    expect_next("jal2", 32'h200, 0, 0, 0); step();
    jump_reg = 1; jump_link = 1; is_return = 1; reg_target = 32'h108;
    expect_next("jalr_ret", 32'h108, 0, 0, 0); step();
    jump_reg = 1; is_return = 1; reg_target = 32'h204;
    expect_next("ret2", 32'h204, 0, 0, 1); step();

    // Asynchronous reset mid-run
    jump_reg = 1; reg_target = 32'h40;
    expect_next("jr_40", 32'h40, 0, 0, 1); step();
    jump = 1; jump_link = 1; instr_idx = 26'h10;
    expect_next("jal_40", 32'h40, 0, 0, 0); step();
    #2 reset = 1'b1;
    #1;
    cmp("midrst.pc",    pc,             32'h0);
    cmp("midrst.empty", 32'(ras_empty), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    expect_next("post_rst", 32'h4, 0, 0, 1); step();

    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_miss++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
